// File: rtl/text_pixel_pipeline.sv
// Text-mode pixel stage: VRAM char fetch -> font row fetch -> RGB444, syncs delayed 3 cycles.
// Optional blinking cursor enabled by defining TEXT_PIXEL_CURSOR_EN.
module text_pixel_pipeline #(
  parameter int unsigned COLS          = 80,
  parameter int unsigned ROWS          = 30,
  parameter int unsigned WORDS_PER_ROW = COLS / 4
) (
  input  logic        clk_25MHz,
  input  logic        reset_ah,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        vde,
  input  logic [31:0] ctrl,
  output logic [9:0]  vram_addr,
  input  logic [31:0] vram_rdata,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        vde_out
`ifdef TEXT_PIXEL_CURSOR_EN
  ,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row
`endif
);

  localparam int unsigned PIPE_LAT = 3;

  logic [9:0]          r_vram_addr;
  logic [4:0]          r_x0;
  logic [3:0]          r_y0;
  logic [10:0]         r_font_addr;
  logic                r_inv1;
  logic [2:0]          r_x1;
  logic [31:0]         r_ctrl;
  logic [3:0]          r_red, r_green, r_blue;
  logic [PIPE_LAT-1:0] r_hs_sr, r_vs_sr, r_vde_sr;

  logic       w_row_ok;
  logic [9:0] w_addr;
  logic [7:0] w_char;
  logic       w_pix;
  logic       w_cur_flip;
  logic       w_unused;

  assign w_row_ok = drawY[8:4] < 5'(ROWS);
  assign w_addr   = 10'(drawY[8:4] * WORDS_PER_ROW) + 10'(drawX[9:5]);
  assign w_char   = vram_rdata[{r_x0[4:3], 3'b000} +: 8];
  assign w_pix    = font_data[3'd7 - r_x1] ^ r_inv1;
  assign w_unused = ^{drawY[9], ctrl[31:25], ctrl[0]};

`ifdef TEXT_PIXEL_CURSOR_EN
  logic [5:0] r_frame;
  logic       r_vs_d;
  logic       r_cur0;
  logic       w_cell_match;

  // Out-of-range cursor coordinates can never equal a visible cell.
  assign w_cell_match = (drawX[9:3] == cursor_col) && (drawY[8:4] == cursor_row) &&
                        (cursor_col < 7'(COLS)) && (cursor_row < 5'(ROWS));
  assign w_cur_flip   = r_cur0 & r_frame[5];

  always_ff @(posedge clk_25MHz) begin
    if (reset_ah) begin
      r_frame <= '0;
      r_vs_d  <= 1'b1;
      r_cur0  <= 1'b0;
    end else begin
      r_vs_d  <= vsync;
      r_cur0  <= vde & w_cell_match;
      if (r_vs_d && !vsync) r_frame <= r_frame + 6'd1;
    end
  end
`else
  assign w_cur_flip = 1'b0;
`endif

  always_ff @(posedge clk_25MHz) begin
    if (reset_ah) begin
      r_vram_addr <= '0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_font_addr <= '0;
      r_inv1      <= 1'b0;
      r_x1        <= '0;
      r_ctrl      <= '0;
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_hs_sr     <= '1;
      r_vs_sr     <= '1;
      r_vde_sr    <= '0;
    end else begin
      r_vram_addr <= (vde && w_row_ok) ? w_addr : '0;
      r_x0        <= drawX[4:0];
      r_y0        <= drawY[3:0];

      r_font_addr <= {w_char[6:0], r_y0};
      r_inv1      <= w_char[7] ^ w_cur_flip;
      r_x1        <= r_x0[2:0];

      r_ctrl      <= ctrl;
      if (r_vde_sr[1]) begin
        {r_red, r_green, r_blue} <= w_pix ? r_ctrl[24:13] : r_ctrl[12:1];
      end else begin
        {r_red, r_green, r_blue} <= '0;
      end

      r_hs_sr  <= {r_hs_sr[PIPE_LAT-2:0], hsync};
      r_vs_sr  <= {r_vs_sr[PIPE_LAT-2:0], vsync};
      r_vde_sr <= {r_vde_sr[PIPE_LAT-2:0], vde};
    end
  end

  assign vram_addr = r_vram_addr;
  assign font_addr = r_font_addr;
  assign red       = r_red;
  assign green     = r_green;
  assign blue      = r_blue;
  assign hsync_out = r_hs_sr[PIPE_LAT-1];
  assign vsync_out = r_vs_sr[PIPE_LAT-1];
  assign vde_out   = r_vde_sr[PIPE_LAT-1];

endmodule

// File: tb/tb_text_pixel_pipeline.sv
// Bench for text_pixel_pipeline: memories modelled as arrays, outputs predicted from character/glyph rules.
module tb_text_pixel_pipeline;

  logic        clk_25MHz = 1'b0;
  logic        reset_ah;
  logic [9:0]  drawX, drawY;
  logic        hsync, vsync, vde;
  logic [31:0] ctrl;
  logic [9:0]  vram_addr;
  logic [31:0] vram_rdata;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  red, green, blue;
  logic        hsync_out, vsync_out, vde_out;
`ifdef TEXT_PIXEL_CURSOR_EN
  logic [6:0]  cursor_col = 7'd127;
  logic [4:0]  cursor_row = 5'd31;
`endif

  always #5 clk_25MHz = ~clk_25MHz;

  logic [31:0] vram [0:599];
  logic [7:0]  font [0:2047];

  assign vram_rdata = (vram_addr < 10'd600) ? vram[vram_addr] : 32'h0;
  assign font_data  = font[font_addr];

  text_pixel_pipeline dut (
    .clk_25MHz (clk_25MHz),
    .reset_ah  (reset_ah),
    .drawX     (drawX),
    .drawY     (drawY),
    .hsync     (hsync),
    .vsync     (vsync),
    .vde       (vde),
    .ctrl      (ctrl),
    .vram_addr (vram_addr),
    .vram_rdata(vram_rdata),
    .font_addr (font_addr),
    .font_data (font_data),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .vde_out   (vde_out)
`ifdef TEXT_PIXEL_CURSOR_EN
    ,
    .cursor_col(cursor_col),
    .cursor_row(cursor_row)
`endif
  );

  typedef struct {
    logic        rst, vde, hs, vs;
    logic [9:0]  x, y;
    logic [31:0] ctrl;
  } samp_t;

  samp_t       h0, h1, h2;   // inputs seen at the latest three clock edges, newest first
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_edges  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned word_of(input logic v, input logic [9:0] x, input logic [9:0] y);
    return v ? (32'(y) / 16) * 20 + 32'(x) / 32 : 0;
  endfunction

  function automatic logic [7:0] char_of(input logic v, input logic [9:0] x, input logic [9:0] y);
    logic [31:0] w;
    w = vram[word_of(v, x, y)];
    return 8'(w >> (8 * ((32'(x) / 8) % 4)));
  endfunction

  function automatic logic pix_of(input logic [9:0] x, input logic [9:0] y);
    logic [7:0]  ch;
    logic [7:0]  row;
    int unsigned fa;
    ch  = char_of(1'b1, x, y);
    fa  = 32'(ch[6:0]) * 16 + 32'(y) % 16;
    row = font[fa];
    return row[7 - (32'(x) % 8)] ^ ch[7];
  endfunction

  function automatic logic [11:0] colour_of(input samp_t s, input logic [31:0] c);
    if (!s.vde) return 12'h000;
    return pix_of(s.x, s.y) ? c[24:13] : c[12:1];
  endfunction

  task automatic model_compare();
    logic [7:0] ch;
    if (n_edges >= 3) begin
      chk("vram_addr", 32'(vram_addr), h0.rst ? 32'd0 : word_of(h0.vde, h0.x, h0.y));
      ch = char_of(h1.vde, h1.x, h1.y);
      chk("font_addr", 32'(font_addr), h0.rst ? 32'd0 : 32'(ch[6:0]) * 16 + 32'(h1.y) % 16);
      if (h0.rst || h1.rst) begin
        chk("rgb_rst", 32'({red, green, blue}), 32'd0);
        chk("syncs_rst", 32'({hsync_out, vsync_out, vde_out}), 32'b110);
      end else begin
        chk("rgb", 32'({red, green, blue}), 32'(colour_of(h2, h1.ctrl)));
        chk("syncs", 32'({hsync_out, vsync_out, vde_out}), 32'({h2.hs, h2.vs, h2.vde}));
      end
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic hs, input logic vs,
                      input logic [9:0] x, input logic [9:0] y);
    samp_t s;
    reset_ah = rst; vde = v; hsync = hs; vsync = vs; drawX = x; drawY = y;
    @(posedge clk_25MHz);
    s.rst = rst; s.ctrl = ctrl;
    // A reset edge looks to later stages like an idle blanking pixel at (0,0).
    if (rst) begin
      s.vde = 1'b0; s.hs = 1'b1; s.vs = 1'b1; s.x = '0; s.y = '0;
    end else begin
      s.vde = v; s.hs = hs; s.vs = vs; s.x = x; s.y = y;
    end
    h2 = h1; h1 = h0; h0 = s;
    n_edges++;
    #1;
    model_compare();
  endtask

  logic lit_on [0:15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                          1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    for (int i = 0; i < 600; i++) vram[i] = $urandom();
    for (int i = 0; i < 2048; i++) font[i] = 8'($urandom());
    vram[0]         = 32'h0000C141;
    font[16'h41*16] = 8'h18;

    reset_ah = 1'b1; vde = 1'b0; hsync = 1'b1; vsync = 1'b1;
    drawX = '0; drawY = '0; ctrl = 32'h001F6000;

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0);
    chk("reset_rgb", 32'({red, green, blue}), 32'd0);
    chk("reset_vde_out", 32'(vde_out), 32'd0);
    chk("reset_hsync_out", 32'(hsync_out), 32'd1);
    chk("reset_vsync_out", 32'(vsync_out), 32'd1);
    chk("reset_vram_addr", 32'(vram_addr), 32'd0);

    // 'A' then inverted 'A' across the first 16 pixels of row 0
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 10'(i), 10'd0);
      if (i >= 2) begin
        chk("glyph_row0", 32'({red, green, blue}), lit_on[i-2] ? 32'h0FB : 32'h000);
        chk("glyph_vde", 32'(vde_out), 32'd1);
      end
    end

    step(1'b0, 1'b1, 1'b1, 1'b1, 10'd639, 10'd479);
    chk("last_cell_addr", 32'(vram_addr), 32'd599);
    step(1'b0, 1'b1, 1'b1, 1'b1, 10'd638, 10'd479);
    step(1'b0, 1'b0, 1'b1, 1'b1, 10'd100, 10'd500);
    chk("blank_addr", 32'(vram_addr), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 10'd101, 10'd500);
    step(1'b0, 1'b0, 1'b1, 1'b1, 10'd102, 10'd500);
    chk("blank_rgb", 32'({red, green, blue}), 32'd0);
    chk("blank_vde_out", 32'(vde_out), 32'd0);

    ctrl = 32'h01E00014;   // fg F00, bg 00A
    for (int i = 0; i < 400; i++) begin
      if (i == 200) ctrl = $urandom();
      step(1'b0, ($urandom_range(3) != 0), 1'($urandom()), 1'($urandom()),
           10'($urandom_range(639)), 10'($urandom_range(479)));
    end

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 10'(200 + i), 10'd40);
    step(1'b1, 1'b1, 1'b0, 1'b0, 10'd204, 10'd40);
    chk("midline_rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("midline_rst_hs", 32'(hsync_out), 32'd1);
    chk("midline_rst_vs", 32'(vsync_out), 32'd1);
    chk("midline_rst_vde", 32'(vde_out), 32'd0);
    chk("midline_rst_font", 32'(font_addr), 32'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'($urandom()), 1'($urandom()), 10'(8 * i), 10'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
